cci_mpf_csr_mgr: RTL

- Central MPF CSR manager: the single block that decodes host MMIO writes/reads for all MPF shims.
- Drives VTP configuration (mode, page table base) and returns VTP/WRO statistics counters to the host.
- MMIO has no flow control, so all accepted read requests are buffered in a local FIFO and drained as the response channel allows.
- Sits between the CCI MMIO request/response channels and the shim-facing CSR signal set.

---
 rtl/cci_mpf_csr_mgr.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/cci_mpf_csr_mgr.sv
// -----------------------------------------------------------------------------
// cci_mpf_csr_mgr
//   Central MPF CSR manager. It decodes host MMIO writes and reads for all MPF
//   shims, drives the VTP configuration and returns VTP/WRO statistics.
//   MMIO reads have no flow control, so every accepted read is queued in a
//   local FIFO and answered when the response channel has room.
//
// Optional feature macro: MPF_CSR_COUNTER_SNAPSHOT_EN
//   Defined   : a write to idx 8 latches all six counters into shadow
//               registers, and reads of idx 2-7 return the shadows.
//   Undefined : idx 8 writes are ignored, and reads of idx 2-7 return the live
//               counters sampled in the POP state.
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   mmio_wr_valid/addr/data       host write (one cycle per write)
//   mmio_rd_valid/addr/tid        host read request
//   mmio_rsp_almost_full          response channel backpressure
//   mmio_rsp_valid/tid/data       read response
//   vtp_in_mode                   bit0 enable, bit1 TLB invalidate pulse
//   vtp_in_page_table_base(_valid) page table line address, and a flag that
//                                 is set once the base has been written
//   vtp_out_*, wro_out_*          statistics counters from the shims
//   rd_overflow                   sticky: a read was dropped on a full FIFO
// -----------------------------------------------------------------------------
module cci_mpf_csr_mgr #(
   parameter logic [15:0] CSR_BASE_ADDR = 16'h0400,
   parameter int          RD_FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mmio_wr_valid,
   input  logic [15:0] mmio_wr_addr,
   input  logic [63:0] mmio_wr_data,
   input  logic        mmio_rd_valid,
   input  logic [15:0] mmio_rd_addr,
   input  logic [8:0]  mmio_rd_tid,
   input  logic        mmio_rsp_almost_full,
   output logic        mmio_rsp_valid,
   output logic [8:0]  mmio_rsp_tid,
   output logic [63:0] mmio_rsp_data,
   output logic [3:0]  vtp_in_mode,
   output logic [41:0] vtp_in_page_table_base,
   output logic        vtp_in_page_table_base_valid,
   input  logic [63:0] vtp_out_num_hits,
   input  logic [63:0] vtp_out_num_misses,
   input  logic [63:0] wro_out_num_writes,
   input  logic [63:0] wro_out_num_reads,
   input  logic [63:0] wro_out_num_write_conflicts,
   input  logic [63:0] wro_out_num_read_conflicts,
   output logic        rd_overflow
);

   localparam int AW = $clog2(RD_FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, POP, RESP} state_t;

   // ---------------- address decode ----------------
   // A hit is an even word address whose offset from the base maps to idx 0..8.
   logic [15:0] wr_off, rd_off;
   logic        wr_hit, rd_hit;
   logic [3:0]  wr_idx, rd_idx;

   assign wr_off = mmio_wr_addr - CSR_BASE_ADDR;
   assign rd_off = mmio_rd_addr - CSR_BASE_ADDR;
   assign wr_hit = mmio_wr_valid && !mmio_wr_addr[0] && (wr_off[15:1] <= 15'd8);
   assign rd_hit = mmio_rd_valid && !mmio_rd_addr[0] && (rd_off[15:1] <= 15'd8);
   assign wr_idx = wr_off[4:1];
   assign rd_idx = rd_off[4:1];

   // ---------------- configuration registers ----------------
   logic mode_en, tlb_inv;

   assign vtp_in_mode = {2'b00, tlb_inv, mode_en};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mode_en                      <= 1'b0;
         tlb_inv                      <= 1'b0;
         vtp_in_page_table_base       <= '0;
         vtp_in_page_table_base_valid <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments keep every register updating from
         // the same pre-edge values, regardless of statement order.
         tlb_inv <= 1'b0;  // invalidate is a single-cycle pulse
         if (wr_hit && wr_idx == 4'd0) begin
            mode_en <= mmio_wr_data[0];
            tlb_inv <= mmio_wr_data[1];
         end
         if (wr_hit && wr_idx == 4'd1) begin
            vtp_in_page_table_base       <= mmio_wr_data[47:6];
            vtp_in_page_table_base_valid <= 1'b1;
         end
      end
   end

   // ---------------- counter sources ----------------
   logic [63:0] cnt_live [6];
   logic [63:0] cnt_src  [6];

   assign cnt_live[0] = vtp_out_num_hits;
   assign cnt_live[1] = vtp_out_num_misses;
   assign cnt_live[2] = wro_out_num_writes;
   assign cnt_live[3] = wro_out_num_reads;
   assign cnt_live[4] = wro_out_num_write_conflicts;
   assign cnt_live[5] = wro_out_num_read_conflicts;

`ifdef MPF_CSR_COUNTER_SNAPSHOT_EN
   logic [63:0] cnt_shadow [6];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 6; i++) cnt_shadow[i] <= '0;
      end else if (wr_hit && wr_idx == 4'd8) begin
         for (int i = 0; i < 6; i++) cnt_shadow[i] <= cnt_live[i];
      end
   end

   assign cnt_src = cnt_shadow;
`else
   assign cnt_src = cnt_live;
`endif

   // ---------------- read request FIFO ----------------
   logic [12:0] fifo_mem [RD_FIFO_DEPTH];  // {tid, idx}
   logic [AW:0] wr_ptr, rd_ptr;
   logic        fifo_empty, fifo_full, push, pop;

   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A pop in the same cycle frees a slot, so a push into a full FIFO is kept.
   assign push       = rd_hit && (!fifo_full || pop);

   // NOTE: the storage array has no reset; the pointers alone define which
   // entries are valid, so clearing the data would add logic for nothing.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= {mmio_rd_tid, rd_idx};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         rd_overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (rd_hit && !push) rd_overflow <= 1'b1;
      end
   end

   // ---------------- response FSM ----------------
   state_t      state, state_nxt;
   logic [8:0]  pop_tid;
   logic [3:0]  pop_idx;
   logic [63:0] rd_sel;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (pop) state_nxt = POP;
         POP:     state_nxt = RESP;
         RESP:    state_nxt = pop ? POP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // almost_full is only looked at when leaving IDLE or RESP.
   always_comb begin
      pop            = (state == IDLE || state == RESP) && !fifo_empty && !mmio_rsp_almost_full;
      mmio_rsp_valid = (state == RESP);
   end

   // NOTE: every branch assigns rd_sel after a default, so no latch is inferred.
   always_comb begin
      rd_sel = '0;
      case (pop_idx)
         4'd0:    rd_sel = {60'b0, vtp_in_mode};
         4'd1:    rd_sel = {22'b0, vtp_in_page_table_base};
         4'd2:    rd_sel = cnt_src[0];
         4'd3:    rd_sel = cnt_src[1];
         4'd4:    rd_sel = cnt_src[2];
         4'd5:    rd_sel = cnt_src[3];
         4'd6:    rd_sel = cnt_src[4];
         4'd7:    rd_sel = cnt_src[5];
         default: rd_sel = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pop_tid       <= '0;
         pop_idx       <= '0;
         mmio_rsp_tid  <= '0;
         mmio_rsp_data <= '0;
      end else begin
         if (pop) {pop_tid, pop_idx} <= fifo_mem[rd_ptr[AW-1:0]];
         if (state == POP) begin
            mmio_rsp_tid  <= pop_tid;
            mmio_rsp_data <= rd_sel;
         end
      end
   end

endmodule
